// File: rtl/i2s_rx_sample_packer_if.sv
// i2s_rx_sample_packer_if: sample-in and packed-word-out handshakes of the RX packer.
// The slave modport is the packer side; master is the RX channel / uDMA side.
interface i2s_rx_sample_packer_if #(
  parameter int DW = 32
);
  logic [DW-1:0] in_data_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i;

  modport slave (
    input  in_data_i,
    input  in_valid_i,
    input  out_ready_i,
    output in_ready_o,
    output out_data_o,
    output out_valid_o
  );

  modport master (
    output in_data_i,
    output in_valid_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_data_o,
    input  out_valid_o
  );
endinterface

// File: rtl/i2s_rx_sample_packer.sv
// i2s_rx_sample_packer: packs 8/16-bit RX samples into 32-bit words (or passes
// wider samples through masked) and queues the words in a DEPTH-entry FIFO.
module i2s_rx_sample_packer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                   sck_i,
  input  logic                   rstn_i,
  input  logic                   cfg_en_i,
  input  logic                   cfg_clr_i,
  input  logic                   cfg_pack_i,
  input  logic [4:0]             cfg_num_bits_i,
  i2s_rx_sample_packer_if.slave  bus,
  output logic                   err_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  function automatic logic [DATA_WIDTH-1:0] f_sample_mask(input logic [4:0] nb);
    case (nb)
      5'd7:    f_sample_mask = 32'h0000_00FF;
      5'd15:   f_sample_mask = 32'h0000_FFFF;
      5'd23:   f_sample_mask = 32'h00FF_FFFF;
      default: f_sample_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [1:0] f_last_lane(input logic pack, input logic [4:0] nb);
    if (pack && (nb == 5'd7)) begin
      f_last_lane = 2'd3;
    end else if (pack && (nb == 5'd15)) begin
      f_last_lane = 2'd1;
    end else begin
      f_last_lane = 2'd0;
    end
  endfunction

  // Bit offset of a lane: 8 bits per lane in byte mode, 16 in half-word mode.
  function automatic logic [4:0] f_lane_shift(input logic [1:0] last, input logic [1:0] lane);
    case (last)
      2'd3:    f_lane_shift = {lane, 3'b000};
      2'd1:    f_lane_shift = {lane[0], 4'b0000};
      default: f_lane_shift = 5'd0;
    endcase
  endfunction

  logic                  r_run;
  logic                  r_pack_q;
  logic [4:0]            r_nb_q;
  logic [1:0]            r_lane;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  r_err;

  logic [AW:0]           w_level;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_cfg_chg;
  logic [1:0]            w_last;
  logic [1:0]            w_lane;
  logic                  w_lane_last;
  logic [DATA_WIDTH-1:0] w_acc_base;
  logic [DATA_WIDTH-1:0] w_sample;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_push;
  logic                  w_pop;
  logic [1:0]            w_lane_nxt;
  logic [DATA_WIDTH-1:0] w_acc_nxt;

  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_level == LVL_FULL);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  // Ready is built from state and config only; the upstream valid depends on it.
  assign w_in_ready = r_run & cfg_en_i & ~w_full & ~cfg_clr_i;
  assign w_accept   = bus.in_valid_i & w_in_ready;
  assign w_pop      = ~w_empty & bus.out_ready_i;

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = ~w_empty;
  assign bus.out_data_o  = w_empty ? {DATA_WIDTH{1'b0}} : r_mem[r_rd_ptr[AW-1:0]];
  assign err_o           = r_err;
  assign level_o         = w_level;

  // Lane selection and word assembly for the sample offered this cycle.
  always_comb begin
    w_cfg_chg   = cfg_en_i & ((cfg_pack_i != r_pack_q) | (cfg_num_bits_i != r_nb_q));
    w_last      = f_last_lane(cfg_pack_i, cfg_num_bits_i);
    w_lane      = w_cfg_chg ? 2'd0 : r_lane;
    w_acc_base  = w_cfg_chg ? {DATA_WIDTH{1'b0}} : r_acc;
    w_lane_last = (w_lane == w_last);
    w_sample    = bus.in_data_i & f_sample_mask(cfg_num_bits_i);
    w_word      = w_acc_base | (w_sample << f_lane_shift(w_last, w_lane));
    w_push      = w_accept & w_lane_last;
  end

  // Next lane counter / accumulator: clear, advance, or discard on mode change.
  always_comb begin
    w_lane_nxt = r_lane;
    w_acc_nxt  = r_acc;
    if (cfg_clr_i || !cfg_en_i) begin
      w_lane_nxt = 2'd0;
      w_acc_nxt  = {DATA_WIDTH{1'b0}};
    end else if (w_accept) begin
      if (w_lane_last) begin
        w_lane_nxt = 2'd0;
        w_acc_nxt  = {DATA_WIDTH{1'b0}};
      end else begin
        w_lane_nxt = w_lane + 2'd1;
        w_acc_nxt  = w_word;
      end
    end else if (w_cfg_chg) begin
      w_lane_nxt = 2'd0;
      w_acc_nxt  = {DATA_WIDTH{1'b0}};
    end else begin
      w_lane_nxt = r_lane;
      w_acc_nxt  = r_acc;
    end
  end

  // Config shadow copies and the out-of-reset flag gating in_ready_o.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_run    <= 1'b0;
      r_pack_q <= 1'b0;
      r_nb_q   <= 5'd0;
    end else begin
      r_run    <= 1'b1;
      r_pack_q <= cfg_pack_i;
      r_nb_q   <= cfg_num_bits_i;
    end
  end

  // Lane counter and partial-word accumulator.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_lane <= 2'd0;
      r_acc  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_lane <= w_lane_nxt;
      r_acc  <= w_acc_nxt;
    end
  end

  // Output FIFO: storage and wrap-bit pointers; clear beats push and pop.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (cfg_clr_i) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_word;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Sticky overrun flag: a sample offered while the packer was not ready.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_err <= 1'b0;
    end else if (cfg_clr_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | (cfg_en_i & bus.in_valid_i & ~w_in_ready);
    end
  end

endmodule

// File: tb/tb_i2s_rx_sample_packer.sv
// tb_i2s_rx_sample_packer: directed vector table, corner-case sequences and a
// randomized run checked against a queue-based packing model.
module tb_i2s_rx_sample_packer;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct {
    logic        en, clr, pack;
    logic [4:0]  nb;
    logic        valid;
    logic [31:0] data;
    logic        ordy;
    logic        e_rdy, e_ov;
    logic [31:0] e_od;
    logic [LW-1:0] e_lvl;
    logic        e_err;
  } vec_t;

  logic          sck;
  logic          rstn;
  logic          cfg_en, cfg_clr, cfg_pack;
  logic [4:0]    cfg_nb;
  logic          err;
  logic [LW-1:0] level;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[17];

  logic [31:0] m_q[$];
  logic [31:0] m_grp[$];
  bit          m_err, m_run, m_pack_p;
  logic [4:0]  m_nb_p;

  logic        r_pack, r_en, r_clr, r_valid, r_ordy;
  logic [4:0]  r_nb;
  logic [31:0] r_data;

  i2s_rx_sample_packer_if #(.DW(32)) bus ();

  i2s_rx_sample_packer #(.DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .sck_i          (sck),
    .rstn_i         (rstn),
    .cfg_en_i       (cfg_en),
    .cfg_clr_i      (cfg_clr),
    .cfg_pack_i     (cfg_pack),
    .cfg_num_bits_i (cfg_nb),
    .bus            (bus),
    .err_o          (err),
    .level_o        (level)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_rdy, input logic e_ov,
                           input logic [31:0] e_od, input logic [LW-1:0] e_lvl, input logic e_err);
    chk({tag, ".in_ready"},  {31'd0, bus.in_ready_o},  {31'd0, e_rdy});
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid_o}, {31'd0, e_ov});
    chk({tag, ".out_data"},  bus.out_data_o,           e_od);
    chk({tag, ".level"},     32'(level),               32'(e_lvl));
    chk({tag, ".err"},       {31'd0, err},             {31'd0, e_err});
  endtask

  task automatic drive(input logic en, input logic clr, input logic pack, input logic [4:0] nb,
                       input logic valid, input logic [31:0] data, input logic ordy);
    cfg_en         = en;
    cfg_clr        = clr;
    cfg_pack       = pack;
    cfg_nb         = nb;
    bus.in_valid_i = valid;
    bus.in_data_i  = data;
    bus.out_ready_i = ordy;
  endtask

  function automatic vec_t mkv(input logic en, input logic clr, input logic pack, input logic [4:0] nb,
                               input logic valid, input logic [31:0] data, input logic ordy,
                               input logic e_rdy, input logic e_ov, input logic [31:0] e_od,
                               input logic [LW-1:0] e_lvl, input logic e_err);
    vec_t v;
    v.en = en; v.clr = clr; v.pack = pack; v.nb = nb; v.valid = valid; v.data = data; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_lvl = e_lvl; v.e_err = e_err;
    return v;
  endfunction

  // Reference model: samples collect in a group, a full group becomes one word.
  function automatic bit m_ready(input logic en, input logic clr);
    return m_run && (en === 1'b1) && (m_q.size() < DEPTH) && (clr === 1'b0);
  endfunction

  task automatic m_edge(input logic en, input logic clr, input logic pack, input logic [4:0] nb,
                        input logic valid, input logic [31:0] data, input logic ordy);
    bit              rdy;
    int              width;
    int              lanes;
    longint unsigned mask;
    longint unsigned w;
    rdy = m_ready(en, clr);
    if (clr) begin
      m_q.delete();
      m_grp.delete();
      m_err = 1'b0;
    end else begin
      if (en && valid && !rdy) m_err = 1'b1;
      if ((m_q.size() > 0) && ordy) void'(m_q.pop_front());
      if (!en || (pack != m_pack_p) || (nb != m_nb_p)) m_grp.delete();
      if (valid && rdy) begin
        width = ((nb == 5'd7) || (nb == 5'd15) || (nb == 5'd23)) ? (int'(nb) + 1) : 32;
        lanes = (pack && nb == 5'd7) ? 4 : ((pack && nb == 5'd15) ? 2 : 1);
        mask  = (64'd1 << width) - 64'd1;
        m_grp.push_back(32'(64'(data) & mask));
        if (m_grp.size() == lanes) begin
          w = 64'd0;
          for (int k = 0; k < lanes; k++) w = w | (64'(m_grp[k]) << (k * width));
          m_q.push_back(w[31:0]);
          m_grp.delete();
        end
      end
    end
    m_pack_p = pack;
    m_nb_p   = nb;
    m_run    = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mkv(H,L,H,5'd7, H,32'h0000_0011,L, H,L,32'h0,3'd0,L);
    tbl[1]  = mkv(H,L,H,5'd7, H,32'h0000_0022,L, H,L,32'h0,3'd0,L);
    tbl[2]  = mkv(H,L,H,5'd7, H,32'h0000_0033,L, H,L,32'h0,3'd0,L);
    tbl[3]  = mkv(H,L,H,5'd7, H,32'h0000_0044,L, H,L,32'h0,3'd0,L);
    tbl[4]  = mkv(H,L,H,5'd7, L,32'h0,L,         H,H,32'h4433_2211,3'd1,L);
    tbl[5]  = mkv(H,L,H,5'd7, L,32'h0,H,         H,H,32'h4433_2211,3'd1,L);
    tbl[6]  = mkv(H,L,H,5'd15,H,32'h1234_ABCD,L, H,L,32'h0,3'd0,L);
    tbl[7]  = mkv(H,L,H,5'd15,H,32'h0000_5678,L, H,L,32'h0,3'd0,L);
    tbl[8]  = mkv(H,L,H,5'd15,L,32'h0,H,         H,H,32'h5678_ABCD,3'd1,L);
    tbl[9]  = mkv(H,L,L,5'd23,H,32'hFF12_3456,L, H,L,32'h0,3'd0,L);
    tbl[10] = mkv(H,L,L,5'd23,L,32'h0,L,         H,H,32'h0012_3456,3'd1,L);
    tbl[11] = mkv(H,L,L,5'd9, H,32'hDEAD_BEEF,H, H,H,32'h0012_3456,3'd1,L);
    tbl[12] = mkv(H,L,L,5'd9, L,32'h0,L,         H,H,32'hDEAD_BEEF,3'd1,L);
    tbl[13] = mkv(H,L,L,5'd9, L,32'h0,H,         H,H,32'hDEAD_BEEF,3'd1,L);
    tbl[14] = mkv(H,L,L,5'd9, L,32'h0,L,         H,L,32'h0,3'd0,L);
    tbl[15] = mkv(L,L,L,5'd9, H,32'h1234_5678,L, L,L,32'h0,3'd0,L);
    tbl[16] = mkv(H,L,L,5'd9, L,32'h0,L,         H,L,32'h0,3'd0,L);

    // Reset values, with enable and valid already asserted.
    rstn = 1'b0;
    drive(H,L,H,5'd7,H,32'h0000_0055,H);
    #12;
    check_all("reset", L,L,32'h0,3'd0,L);
    drive(L,L,L,5'd0,L,32'h0,L);
    @(posedge sck); #2;
    rstn = 1'b1;
    @(posedge sck);

    for (int i = 0; i < 17; i++) begin
      @(posedge sck); #2;
      drive(tbl[i].en, tbl[i].clr, tbl[i].pack, tbl[i].nb, tbl[i].valid, tbl[i].data, tbl[i].ordy);
      #2;
      check_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_lvl, tbl[i].e_err);
    end

    // Fill to DEPTH, overrun sets err, full blocks ready despite a pop, clear.
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge sck); #2;
      drive(H,L,L,5'd31,H,32'(i + 1),L);
      #2;
      check_all($sformatf("fill%0d", i), H, (i > 0), (i > 0) ? 32'h1 : 32'h0, LW'(i), L);
    end
    @(posedge sck); #2; drive(H,L,L,5'd31,H,32'h5,L); #2;
    check_all("full_offer", L,H,32'h1,3'd4,L);
    @(posedge sck); #2; drive(H,L,L,5'd31,L,32'h0,H); #2;
    check_all("full_pop", L,H,32'h1,3'd4,H);
    @(posedge sck); #2; drive(H,L,L,5'd31,L,32'h0,L); #2;
    check_all("after_pop", H,H,32'h2,3'd3,H);
    @(posedge sck); #2; drive(H,H,L,5'd31,L,32'h0,L); #2;
    check_all("clr_cycle", L,H,32'h2,3'd3,H);
    @(posedge sck); #2; drive(H,L,L,5'd31,L,32'h0,L); #2;
    check_all("after_clr", H,L,32'h0,3'd0,L);

    // Mode switch mid-word discards the partial bytes.
    @(posedge sck); #2; drive(H,L,H,5'd7,H,32'h01,L); #2;
    @(posedge sck); #2; drive(H,L,H,5'd7,H,32'h02,L); #2;
    @(posedge sck); #2; drive(H,L,H,5'd15,H,32'hAAAA,L); #2;
    @(posedge sck); #2; drive(H,L,H,5'd15,H,32'hBBBB,L); #2;
    check_all("switch_in", H,L,32'h0,3'd0,L);
    @(posedge sck); #2; drive(H,L,H,5'd15,L,32'h0,H); #2;
    check_all("switch_word", H,H,32'hBBBB_AAAA,3'd1,L);
    @(posedge sck); #2; drive(H,L,H,5'd15,L,32'h0,L); #2;
    check_all("switch_drain", H,L,32'h0,3'd0,L);

    // Reset with three words queued and a partial group at lane 2.
    for (int k = 0; k < 14; k++) begin
      @(posedge sck); #2; drive(H,L,H,5'd7,H,32'(k + 1),L); #2;
    end
    @(posedge sck); #2; drive(H,L,H,5'd7,L,32'h0,L); #2;
    check_all("pre_reset", H,H,32'h0403_0201,3'd3,L);
    rstn = 1'b0;
    #1;
    check_all("async_reset", L,L,32'h0,3'd0,L);
    @(posedge sck); #2;
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge sck); #2; drive(H,L,H,5'd7,H,32'h11 * (k + 1),L); #2;
      check_all($sformatf("post_reset%0d", k), H,L,32'h0,3'd0,L);
    end
    @(posedge sck); #2; drive(H,L,H,5'd7,L,32'h0,L); #2;
    check_all("post_reset_word", H,H,32'h4433_2211,3'd1,L);

    // Randomized run against the model.
    rstn = 1'b0;
    drive(L,L,L,5'd0,L,32'h0,L);
    m_q.delete(); m_grp.delete();
    m_err = 1'b0; m_run = 1'b0; m_pack_p = 1'b0; m_nb_p = 5'd0;
    @(posedge sck); #2;
    rstn = 1'b1;
    @(posedge sck);
    m_run = 1'b1;
    r_pack = 1'b1;
    r_nb   = 5'd7;
    for (int c = 0; c < 4000; c++) begin
      #2;
      if ($urandom_range(0, 59) == 0) begin
        r_pack = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 4))
          0:       r_nb = 5'd7;
          1:       r_nb = 5'd15;
          2:       r_nb = 5'd23;
          3:       r_nb = 5'd31;
          default: r_nb = 5'($urandom_range(0, 31));
        endcase
      end
      r_en    = ($urandom_range(0, 49) != 0);
      r_clr   = ($urandom_range(0, 149) == 0);
      r_valid = ($urandom_range(0, 9) < 7);
      r_ordy  = ($urandom_range(0, 9) < 5);
      r_data  = $urandom;
      drive(r_en, r_clr, r_pack, r_nb, r_valid, r_data, r_ordy);
      #2;
      check_all("rnd", m_ready(r_en, r_clr), (m_q.size() > 0),
                (m_q.size() > 0) ? m_q[0] : 32'h0, LW'(m_q.size()), m_err);
      m_edge(r_en, r_clr, r_pack, r_nb, r_valid, r_data, r_ordy);
      @(posedge sck);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
